// File: rtl/btb_update_ctrl_if.sv
// btb_update_ctrl_if: execute-side update/flush handshake and BTB write-port bundle.
interface btb_update_ctrl_if #(
    parameter int INDEX_WIDTH  = 6,
    parameter int TARGET_WIDTH = 32
);
    logic                    flushReq;
    logic                    flushBusy;
    logic                    exValid;
    logic                    exReady;
    logic                    exTaken;
    logic [31:0]             exPc;
    logic [TARGET_WIDTH-1:0] exTarget;
    logic                    btbWrEn;
    logic                    btbWrInval;
    logic [INDEX_WIDTH-1:0]  btbWrIndex;
    logic                    btbUpdTaken;
    logic [31:0]             btbUpdPc;
    logic [TARGET_WIDTH-1:0] btbUpdTarget;

    modport master (
        output flushReq, exValid, exTaken, exPc, exTarget,
        input  flushBusy, exReady, btbWrEn, btbWrInval, btbWrIndex, btbUpdTaken, btbUpdPc, btbUpdTarget
    );

    modport slave (
        input  flushReq, exValid, exTaken, exPc, exTarget,
        output flushBusy, exReady, btbWrEn, btbWrInval, btbWrIndex, btbUpdTaken, btbUpdPc, btbUpdTarget
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: owns the BTB write port; sweeps invalidations after reset/flush and drains queued branch updates.
module btb_update_ctrl #(
    parameter int BTB_ENTRIES  = 64,
    parameter int INDEX_WIDTH  = $clog2(BTB_ENTRIES),
    parameter int TARGET_WIDTH = 32,
    parameter int QUEUE_DEPTH  = 4
) (
    input logic clk,
    input logic rst,
    btb_update_ctrl_if.slave bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic {SWEEP, RUN} state_t;

    state_t                  state_q, state_d;
    logic [INDEX_WIDTH-1:0]  sweep_idx_q, sweep_idx_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    taken_q  [QUEUE_DEPTH];
    logic [31:0]             pc_q     [QUEUE_DEPTH];
    logic [TARGET_WIDTH-1:0] target_q [QUEUE_DEPTH];
    logic                    sweeping, push, pop;

    always_comb begin
        sweeping    = state_q == SWEEP;
        pop         = !sweeping && count_q != '0;
        bus.exReady = count_q != CW'(QUEUE_DEPTH) && !bus.flushReq;
        push        = bus.exValid && bus.exReady;
        state_d     = sweeping && sweep_idx_q == INDEX_WIDTH'(BTB_ENTRIES - 1) ? RUN : state_q;
        sweep_idx_d = sweeping ? sweep_idx_q + INDEX_WIDTH'(1) : '0;
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        wr_ptr_d    = wr_ptr_q + PW'(push);
        count_d     = count_q + CW'(push) - CW'(pop);
        // A flush discards queued updates; a pop in this cycle has already been written.
        if (bus.flushReq) begin
            state_d     = SWEEP;
            sweep_idx_d = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
        end
        bus.flushBusy    = sweeping;
        bus.btbWrEn      = sweeping || pop;
        bus.btbWrInval   = sweeping;
        bus.btbWrIndex   = sweeping ? sweep_idx_q : pop ? pc_q[rd_ptr_q][INDEX_WIDTH+1:2] : '0;
        bus.btbUpdTaken  = pop && taken_q[rd_ptr_q];
        bus.btbUpdPc     = pop ? pc_q[rd_ptr_q] : '0;
        bus.btbUpdTarget = pop ? target_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            taken_q[wr_ptr_q]  <= bus.exTaken;
            pc_q[wr_ptr_q]     <= bus.exPc;
            target_q[wr_ptr_q] <= bus.exTarget;
        end
    end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed table, corner sequences and random traffic checked against a queue-based model.
module tb_btb_update_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    btb_update_ctrl_if #(.INDEX_WIDTH(6), .TARGET_WIDTH(32)) bus ();

    btb_update_ctrl #(.BTB_ENTRIES(64), .TARGET_WIDTH(32), .QUEUE_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] tgt;
    } upd_t;

    typedef struct {
        bit          r, f, v, t;
        logic [31:0] pc, tg;
        logic [74:0] exp;
        bit          chk;
    } vec_t;

    upd_t        m_q[$];
    bit          m_sweep = 1'b1;
    bit          m_live  = 1'b0;
    int          m_idx   = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] wr_log[$];
    logic [74:0] last;
    vec_t        tbl[$];

    function automatic logic [74:0] mk(input bit b, input bit rd, input bit e, input bit iv,
                                       input logic [5:0] ix, input bit tk, input logic [31:0] p, input logic [31:0] tg);
        return {b, rd, e, iv, ix, tk, p, tg};
    endfunction

    task automatic check(input string name, input logic [74:0] act, input logic [74:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive, sample and check against the model, then advance the model.
    task automatic cyc(input bit r, input bit f, input bit v, input bit t, input logic [31:0] pc, input logic [31:0] tg);
        logic [74:0] exp;
        bit rdy;
        @(negedge clk);
        rst = r;
        bus.flushReq = f;
        bus.exValid = v;
        bus.exTaken = t;
        bus.exPc = pc;
        bus.exTarget = tg;
        #1;
        rdy = m_q.size() < 4 && !f;
        if (m_sweep) exp = mk(1, rdy, 1, 1, 6'(m_idx), 0, 0, 0);
        else if (m_q.size() > 0) exp = mk(0, rdy, 1, 0, m_q[0].pc[7:2], m_q[0].taken, m_q[0].pc, m_q[0].tgt);
        else exp = mk(0, rdy, 0, 0, 0, 0, 0, 0);
        last = {bus.flushBusy, bus.exReady, bus.btbWrEn, bus.btbWrInval, bus.btbWrIndex,
                bus.btbUpdTaken, bus.btbUpdPc, bus.btbUpdTarget};
        if (m_live) check("model", last, exp);
        if (bus.btbWrEn === 1'b1 && bus.btbWrInval === 1'b0) wr_log.push_back(bus.btbUpdPc);
        @(posedge clk);
        if (r) begin
            m_sweep = 1; m_idx = 0; m_q.delete(); m_live = 1;
        end else if (f) begin
            m_sweep = 1; m_idx = 0; m_q.delete();
        end else begin
            if (m_sweep) begin
                if (m_idx == 63) begin m_sweep = 0; m_idx = 0; end
                else m_idx++;
            end else if (m_q.size() > 0) void'(m_q.pop_front());
            if (v && rdy) m_q.push_back(upd_t'({t, pc, tg}));
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to_idx(input int ix);
        for (int n = 0; n < 100 && !(m_sweep && m_idx == ix); n++) idle();
    endtask

    initial begin
        logic [31:0] pcs[5];
        int k, acc_sweep, busy_n;
        bus.flushReq = 0; bus.exValid = 0; bus.exTaken = 0; bus.exPc = 0; bus.exTarget = 0;

        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, mk(1, 1, 1, 1, 0, 0, 0, 0), 1});
        for (int i = 0; i < 64; i++) tbl.push_back('{0, 0, 0, 0, 0, 0, mk(1, 1, 1, 1, 6'(i), 0, 0, 0), 1});
        tbl.push_back('{0, 0, 1, 1, 32'h104, 32'h200, mk(0, 1, 0, 0, 0, 0, 0, 0), 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, mk(0, 1, 1, 0, 6'd1, 1, 32'h104, 32'h200), 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0), 1});
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].t, tbl[i].pc, tbl[i].tg);
            if (tbl[i].chk) check($sformatf("table row %0d", i), last, tbl[i].exp);
        end

        // Fill the queue during a sweep, then check drain order.
        cyc(0, 1, 0, 0, 0, 0);
        run_to_idx(10);
        wr_log.delete();
        pcs = '{32'h100, 32'h204, 32'h308, 32'h40c, 32'h510};
        k = 0; acc_sweep = 0;
        for (int n = 0; n < 200 && k < 5; n++) begin
            cyc(0, 0, 1, k[0], pcs[k], pcs[k] + 32'h1000);
            if (last[73]) begin
                if (last[74]) acc_sweep++;
                k++;
            end
        end
        check_int("accepted during sweep", acc_sweep, 4);
        check_int("all five accepted", k, 5);
        repeat (8) idle();
        check_int("fill write count", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) check_int($sformatf("fill order %0d", i), int'(wr_log[i]), int'(pcs[i]));

        // Flush on the cycle the first queued update is written.
        wr_log.delete();
        cyc(0, 0, 1, 0, 32'h10, 32'h50);
        cyc(0, 1, 1, 0, 32'h20, 32'h60);
        check("flush-cycle write", last, mk(0, 0, 1, 0, 6'd4, 0, 32'h10, 32'h50));
        cyc(0, 0, 0, 0, 0, 0);
        check("sweep after flush", last, mk(1, 1, 1, 1, 0, 0, 0, 0));
        repeat (70) idle();
        check_int("flush writes", wr_log.size(), 1);
        if (wr_log.size() > 0) check_int("flush kept pc", int'(wr_log[0]), 32'h10);

        // Re-flush mid-sweep restarts the full 64-cycle sweep.
        cyc(0, 1, 0, 0, 0, 0);
        run_to_idx(30);
        cyc(0, 1, 0, 0, 0, 0);
        busy_n = 0;
        for (int n = 0; n < 100; n++) begin
            idle();
            if (last[74]) busy_n++;
            else break;
        end
        check_int("busy after reflush", busy_n, 64);

        // Reset mid-sweep with two queued updates.
        cyc(0, 1, 0, 0, 0, 0);
        run_to_idx(38);
        wr_log.delete();
        cyc(0, 0, 1, 1, 32'ha0, 32'h1);
        cyc(0, 0, 1, 0, 32'hb0, 32'h2);
        cyc(1, 0, 0, 0, 0, 0);
        idle();
        check("sweep after reset", last, mk(1, 1, 1, 1, 0, 0, 0, 0));
        repeat (70) idle();
        check_int("writes after reset", wr_log.size(), 0);

        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
                1'($urandom), $urandom, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
